bi_mem_wm_2p: RTL and testbench

- Parametrised simple-dual-port memory with per-chunk write mask: one write port and one read port, sharing one clock.
- Read path has a configurable pipeline depth.
- Same-cycle same-address write-to-read forwarding is applied per mask chunk.
- Generic behavioural implementation for the "default" profile; it is the next generation of the single-port write-masked memory and is used for register files, packet buffers and scratchpads.

---
 rtl/bi_mem_wm_2p.sv | 136 +++++++++++++
 tb/tb_bi_mem_wm_2p.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bi_mem_wm_2p.sv
// Simple-dual-port memory with per-chunk write mask and same-edge write-to-read forwarding (optional clear: BI_MEM_WM_CLEAR_EN).
// Latency: read data and rdValid_o appear LATENCY cycles after an accepted read; writes commit at the accepting edge.
// Backpressure: none; requests while busy_o=1 or during reset are dropped, never queued.
module bi_mem_wm_2p #(
    parameter string PROFILE = "default",
    parameter int    WIDTH   = 32,
    parameter int    HEIGHT  = 64,
    parameter int    MASK    = 4,
    parameter int    LATENCY = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wrEnable_i,
    input  logic [MASK-1:0]           wrMask_i,
    input  logic [$clog2(HEIGHT)-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]          wrData_i,
    input  logic                      rdEnable_i,
    input  logic [$clog2(HEIGHT)-1:0] rdAddr_i,
    output logic [WIDTH-1:0]          rdData_o,
    output logic                      rdValid_o,
    output logic                      busy_o
);

    localparam int AW    = $clog2(HEIGHT);
    localparam int CHUNK = (WIDTH + MASK - 1) / MASK;
    localparam logic [AW:0] DEPTH = (AW+1)'(HEIGHT);
    localparam logic [AW:0] LAST  = (AW+1)'(HEIGHT - 1);

    // The last mask bit naturally covers the shorter remainder chunk.
    logic [WIDTH-1:0] bit_mask;
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign bit_mask[b] = wrMask_i[b / CHUNK];
    end

    if (PROFILE == "default" && LATENCY >= 1 && LATENCY <= 4) begin : g_mem
        logic [WIDTH-1:0] mem [HEIGHT];
        logic             busy;
        logic             wr_ok;
        logic             rd_ok;
        logic             wr_go;
        logic             rd_go;
        logic [WIDTH-1:0] old_word;
        logic [WIDTH-1:0] rd_word;
        logic [LATENCY-1:0] pipe_vld;
        logic [WIDTH-1:0]   pipe_dat [LATENCY];

`ifdef BI_MEM_WM_CLEAR_EN
        typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
        state_t          state_q;
        state_t          state_d;
        logic [AW-1:0]   clr_cnt_q;
        logic [AW-1:0]   clr_cnt_d;
        logic            clr_we;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q   <= ST_CLEAR;
                clr_cnt_q <= '0;
            end else begin
                state_q   <= state_d;
                clr_cnt_q <= clr_cnt_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            clr_cnt_d = clr_cnt_q;
            clr_we    = 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + AW'(1);
                    if ({1'b0, clr_cnt_q} == LAST) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        assign busy = (state_q == ST_CLEAR);
`else
        assign busy = 1'b0;
`endif

        assign wr_ok    = ({1'b0, wrAddr_i} < DEPTH);
        assign rd_ok    = ({1'b0, rdAddr_i} < DEPTH);
        assign wr_go    = wrEnable_i & ~busy & wr_ok;
        assign rd_go    = rdEnable_i & ~busy;
        assign old_word = rd_ok ? mem[rdAddr_i] : '0;
        // Same-edge hit: masked chunks come from the incoming write data.
        assign rd_word  = (wr_go && (wrAddr_i == rdAddr_i))
                        ? ((old_word & ~bit_mask) | (wrData_i & bit_mask))
                        : old_word;

        always_ff @(posedge clk_i) begin
`ifdef BI_MEM_WM_CLEAR_EN
            if (!rst_i && clr_we)
                mem[clr_cnt_q] <= '0;
            else
`endif
            if (!rst_i && wr_go)
                mem[wrAddr_i] <= (mem[wrAddr_i] & ~bit_mask) | (wrData_i & bit_mask);
        end

        // Data stages only advance with a valid, so the last stage holds between reads.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_vld <= '0;
                for (int k = 0; k < LATENCY; k++) pipe_dat[k] <= '0;
            end else begin
                pipe_vld[0] <= rd_go;
                if (rd_go) pipe_dat[0] <= rd_word;
                for (int k = 1; k < LATENCY; k++) begin
                    pipe_vld[k] <= pipe_vld[k-1];
                    if (pipe_vld[k-1]) pipe_dat[k] <= pipe_dat[k-1];
                end
            end
        end

        assign rdValid_o = pipe_vld[LATENCY-1];
        assign rdData_o  = pipe_dat[LATENCY-1];
        assign busy_o    = busy;
    end else begin : g_panic
        PanicModule u_panic ();
        assign rdData_o  = '0;
        assign rdValid_o = 1'b0;
        assign busy_o    = 1'b0;
    end

endmodule

// Elaboration marker for unsupported profiles or latencies.
module PanicModule;
endmodule

// File: tb/tb_bi_mem_wm_2p.sv
// Directed bench for bi_mem_wm_2p: five instances sharing one clock, checked by a scoreboard monitor.
module tb_bi_mem_wm_2p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntests = 0;
    int nfail  = 0;

    logic        rst [5];
    logic        we  [5];
    logic        re  [5];
    logic [3:0]  wm  [5];
    logic [5:0]  wa  [5];
    logic [5:0]  ra  [5];
    logic [31:0] wd  [5];

    logic [31:0] rd0, rd2, rd3, rd4;
    logic [9:0]  rd1;
    logic        rv0, rv1, rv2, rv3, rv4;
    logic        bz0, bz1, bz2, bz3, bz4;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } exp_t;
    exp_t exp_q [5][$];

    // 0: HEIGHT=48  1: WIDTH=10  2: LATENCY=3  3: LATENCY=2  4: HEIGHT=16
    bi_mem_wm_2p #(.WIDTH(32), .HEIGHT(48), .MASK(4), .LATENCY(1)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .wrEnable_i(we[0]), .wrMask_i(wm[0]), .wrAddr_i(wa[0]),
        .wrData_i(wd[0]), .rdEnable_i(re[0]), .rdAddr_i(ra[0]), .rdData_o(rd0), .rdValid_o(rv0), .busy_o(bz0));
    bi_mem_wm_2p #(.WIDTH(10), .HEIGHT(64), .MASK(4), .LATENCY(1)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .wrEnable_i(we[1]), .wrMask_i(wm[1]), .wrAddr_i(wa[1]),
        .wrData_i(wd[1][9:0]), .rdEnable_i(re[1]), .rdAddr_i(ra[1]), .rdData_o(rd1), .rdValid_o(rv1), .busy_o(bz1));
    bi_mem_wm_2p #(.WIDTH(32), .HEIGHT(64), .MASK(4), .LATENCY(3)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .wrEnable_i(we[2]), .wrMask_i(wm[2]), .wrAddr_i(wa[2]),
        .wrData_i(wd[2]), .rdEnable_i(re[2]), .rdAddr_i(ra[2]), .rdData_o(rd2), .rdValid_o(rv2), .busy_o(bz2));
    bi_mem_wm_2p #(.WIDTH(32), .HEIGHT(64), .MASK(4), .LATENCY(2)) u_d (
        .clk_i(clk), .rst_i(rst[3]), .wrEnable_i(we[3]), .wrMask_i(wm[3]), .wrAddr_i(wa[3]),
        .wrData_i(wd[3]), .rdEnable_i(re[3]), .rdAddr_i(ra[3]), .rdData_o(rd3), .rdValid_o(rv3), .busy_o(bz3));
    bi_mem_wm_2p #(.WIDTH(32), .HEIGHT(16), .MASK(4), .LATENCY(1)) u_e (
        .clk_i(clk), .rst_i(rst[4]), .wrEnable_i(we[4]), .wrMask_i(wm[4]), .wrAddr_i(wa[4][3:0]),
        .wrData_i(wd[4]), .rdEnable_i(re[4]), .rdAddr_i(ra[4][3:0]), .rdData_o(rd4), .rdValid_o(rv4), .busy_o(bz4));

    function automatic int lat_of(input int i);
        case (i)
            2:       return 3;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        case (i)
            0:       return rd0;
            1:       return {22'b0, rd1};
            2:       return rd2;
            3:       return rd3;
            default: return rd4;
        endcase
    endfunction

    function automatic logic get_rv(input int i);
        case (i)
            0:       return rv0;
            1:       return rv1;
            2:       return rv2;
            3:       return rv3;
            default: return rv4;
        endcase
    endfunction

    function automatic logic get_bz(input int i);
        case (i)
            0:       return bz0;
            1:       return bz1;
            2:       return bz2;
            3:       return bz3;
            default: return bz4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input int i, input bit w, input logic [5:0] wad, input logic [31:0] wdat,
                         input logic [3:0] m, input bit r, input logic [5:0] rad,
                         input bit expect_rsp, input logic [31:0] edat);
        exp_t e;
        we[i] = w; wa[i] = wad; wd[i] = wdat; wm[i] = m;
        re[i] = r; ra[i] = rad;
        if (r && expect_rsp) begin
            e.dat = edat;
            e.due = cyc + lat_of(i);
            exp_q[i].push_back(e);
        end
        @(posedge clk); #1;
        we[i] = 1'b0;
        re[i] = 1'b0;
    endtask

    task automatic wr(input int i, input logic [5:0] a, input logic [31:0] d, input logic [3:0] m);
        drive(i, 1'b1, a, d, m, 1'b0, 6'd0, 1'b0, 32'd0);
    endtask

    task automatic rd(input int i, input logic [5:0] a, input logic [31:0] e);
        drive(i, 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, a, 1'b1, e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bz0 | bz1 | bz2 | bz3 | bz4) && n < 500) begin
            n++;
            step(1);
        end
        check("wait_idle_timeout", 32'(n >= 500), 32'd0);
    endtask

    task automatic count_busy(input int i, output int n);
        n = 0;
        while (get_bz(i) && n < 100) begin
            re[i] = (n == 3);
            ra[i] = 6'd2;
            n++;
            step(1);
        end
        re[i] = 1'b0;
    endtask

    // Scoreboard monitor: every valid must match the head of its queue, data and cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            if (get_rv(i) === 1'b1) begin
                ntests++;
                if (exp_q[i].size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_valid inst %0d: got data %h at cycle %0d, required no valid",
                             i, get_rd(i), cyc);
                end else begin
                    e = exp_q[i].pop_front();
                    if (get_rd(i) !== e.dat || cyc != e.due) begin
                        nfail++;
                        $display("FAIL rd_data inst %0d: got %h at cycle %0d, required %h at cycle %0d",
                                 i, get_rd(i), cyc, e.dat, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 5; i++) begin
            rst[i] = 1'b1; we[i] = 1'b0; re[i] = 1'b0;
            wm[i] = '0; wa[i] = '0; ra[i] = '0; wd[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_valid_%0d", i), 32'(get_rv(i)), 32'd0);
            check($sformatf("reset_data_%0d", i), get_rd(i), 32'd0);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) rst[i] = 1'b0;
        wait_idle();
`ifndef BI_MEM_WM_CLEAR_EN
        for (int i = 0; i < 5; i++) check($sformatf("busy_tied_%0d", i), 32'(get_bz(i)), 32'd0);
`endif

        // HEIGHT=48: masked merge, out-of-range write dropped, OOR read returns zero.
        for (int a = 0; a < 48; a++) wr(0, 6'(a), 32'hA000_0000 | 32'(a), 4'hF);
        wr(0, 6'd5, 32'hAABBCCDD, 4'b1111);
        wr(0, 6'd5, 32'h11223344, 4'b0101);
        rd(0, 6'd5, 32'hAA22CC44);
        wr(0, 6'd50, 32'hDEADBEEF, 4'b1111);
        rd(0, 6'd50, 32'h0);
        for (int a = 0; a < 48; a++)
            rd(0, 6'(a), (a == 5) ? 32'hAA22CC44 : (32'hA000_0000 | 32'(a)));

        // WIDTH=10: chunks of 3,3,3 and a 1-bit remainder.
        wr(1, 6'd3, 32'h0, 4'b1111);
        wr(1, 6'd3, 32'h3FF, 4'b1000);
        rd(1, 6'd3, 32'h200);
        wr(1, 6'd3, 32'h3FF, 4'b0100);
        rd(1, 6'd3, 32'h3C0);
        wr(1, 6'd3, 32'h3FF, 4'b0000);
        rd(1, 6'd3, 32'h3C0);
        wr(1, 6'd3, 32'h3FF, 4'b0001);
        rd(1, 6'd3, 32'h3C7);

        // LATENCY=3: same-edge forwarding per chunk, independent addresses.
        wr(2, 6'd7, 32'h12345678, 4'b1111);
        drive(2, 1'b1, 6'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 6'd7, 1'b1, 32'h1234FFFF);
        drive(2, 1'b1, 6'd8, 32'hCAFEBABE, 4'b1111, 1'b1, 6'd7, 1'b1, 32'h1234FFFF);
        rd(2, 6'd8, 32'hCAFEBABE);
        drive(2, 1'b1, 6'd8, 32'h0, 4'b0000, 1'b1, 6'd8, 1'b1, 32'hCAFEBABE);
        rd(2, 6'd7, 32'h1234FFFF);
        step(5);

        // LATENCY=2: reset flushes the two reads still in flight and ignores a write.
        for (int a = 0; a < 4; a++) wr(3, 6'(a), 32'hD0 + 32'(a), 4'hF);
        step(3);
        rd(3, 6'd0, 32'hD0);
        rd(3, 6'd1, 32'hD1);
        drive(3, 1'b0, 6'd0, 32'd0, 4'd0, 1'b1, 6'd2, 1'b0, 32'd0);
        rst[3] = 1'b1;
        drive(3, 1'b1, 6'd0, 32'h00000BAD, 4'b1111, 1'b1, 6'd3, 1'b0, 32'd0);
        rst[3] = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(rv3), 32'd0);
        check("flush_data", rd3, 32'd0);
        @(posedge clk); #1;
        wait_idle();
`ifdef BI_MEM_WM_CLEAR_EN
        rd(3, 6'd0, 32'h0);
        rd(3, 6'd1, 32'h0);
`else
        rd(3, 6'd0, 32'hD0);
        rd(3, 6'd1, 32'hD1);
`endif

        // HEIGHT=16: clear sequence and its restart on a mid-clear reset.
`ifdef BI_MEM_WM_CLEAR_EN
        rst[4] = 1'b1; step(1); rst[4] = 1'b0;
        count_busy(4, n);
        check("clear_busy_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) wr(4, 6'(a), 32'hFFFFFFFF, 4'hF);
        rd(4, 6'd9, 32'hFFFFFFFF);
        rst[4] = 1'b1; step(1); rst[4] = 1'b0;
        step(8);
        check("busy_mid_clear", 32'(bz4), 32'd1);
        rst[4] = 1'b1; step(1); rst[4] = 1'b0;
        count_busy(4, n);
        check("clear_restart_busy_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) rd(4, 6'(a), 32'h0);
`else
        wr(4, 6'd15, 32'h0F0F0F0F, 4'hF);
        wr(4, 6'd15, 32'hF0F0F0F0, 4'b1010);
        rd(4, 6'd15, 32'hF00FF00F);
        count_busy(4, n);
        check("busy_never", 32'(n), 32'd0);
`endif

        step(10);
        for (int i = 0; i < 5; i++)
            check($sformatf("queue_empty_%0d", i), 32'(exp_q[i].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
